// File: rtl/div_unit_24bit_if.sv
// Request/result bundle for the multi-cycle divider.
// Overflow exists only when DIV_SIGNED_EN is defined.
interface div_unit_24bit_if #(parameter int WIDTH = 24);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Zero;
  logic             DivByZero;
`ifdef DIV_SIGNED_EN
  logic             Overflow;
`endif

  modport master (
    output Start, Dividend, Divisor,
    input  Busy, Done, Quotient, Remainder, Zero, DivByZero
`ifdef DIV_SIGNED_EN
   ,input  Overflow
`endif
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Busy, Done, Quotient, Remainder, Zero, DivByZero
`ifdef DIV_SIGNED_EN
   ,output Overflow
`endif
  );
endinterface

// File: rtl/div_unit_24bit.sv
// Restoring shift-subtract divider, one quotient bit per clock (IDLE/RUN/FINISH).
// DIV_SIGNED_EN: two's-complement operands via magnitudes plus sign fix-up, adds Overflow.
module div_unit_24bit #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             ResetN,
  div_unit_24bit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] q_q, r_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             zero_q, dbz_q;
  logic [WIDTH:0]   sh, diff;
  logic [WIDTH-1:0] q_step, r_step, q_fin, r_fin, a_mag, b_mag;
  logic             accept, last, dvs_zero;

  assign accept   = (state == IDLE) && bus.Start;
  assign last     = (state == RUN) && (cnt_q == CW'(WIDTH - 1));
  assign dvs_zero = (bus.Divisor == '0);

  // Full WIDTH+1 bit partial remainder so divisors with the MSB set stay exact.
  assign sh     = {r_q, q_q[WIDTH-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign r_step = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_step = {q_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, ovf_pend, ovf_q;
  assign a_mag = bus.Dividend[WIDTH-1] ? (~bus.Dividend + 1'b1) : bus.Dividend;
  assign b_mag = bus.Divisor[WIDTH-1]  ? (~bus.Divisor  + 1'b1) : bus.Divisor;
  assign q_fin = neg_q ? (~q_step + 1'b1) : q_step;
  assign r_fin = neg_r ? (~r_step + 1'b1) : r_step;
  assign bus.Overflow = ovf_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      neg_q <= 1'b0; neg_r <= 1'b0; ovf_pend <= 1'b0; ovf_q <= 1'b0;
    end else if (accept) begin
      neg_q    <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
      neg_r    <= bus.Dividend[WIDTH-1];
      // Only most-negative / -1 has a quotient that does not fit.
      ovf_pend <= (bus.Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Divisor == '1);
      if (dvs_zero) ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= ovf_pend;
    end
  end
`else
  assign a_mag = bus.Dividend;
  assign b_mag = bus.Divisor;
  assign q_fin = q_step;
  assign r_fin = r_step;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = dvs_zero ? FINISH : RUN;
      RUN:     if (last)      state_nxt = FINISH;
      FINISH:                 state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      q_q <= '0; r_q <= '0; dvs_q <= '0; cnt_q <= '0;
      quo_q <= '0; rem_q <= '0; zero_q <= 1'b1; dbz_q <= 1'b0;
    end else if (accept) begin
      q_q   <= a_mag;
      r_q   <= '0;
      dvs_q <= b_mag;
      cnt_q <= '0;
      dbz_q <= 1'b0;
      // Divide-by-zero skips RUN, so its results are loaded here for FINISH.
      if (dvs_zero) begin
        quo_q  <= '1;
        rem_q  <= bus.Dividend;
        zero_q <= 1'b0;
        dbz_q  <= 1'b1;
      end
    end else if (state == RUN) begin
      q_q   <= q_step;
      r_q   <= r_step;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        quo_q  <= q_fin;
        rem_q  <= r_fin;
        zero_q <= (q_fin == '0);
      end
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == FINISH);
  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.Zero      = zero_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_div_unit_24bit.sv
// Bench for div_unit_24bit: vector table and random ops through a scoreboard,
// plus hand sequences for start-while-busy and reset mid-operation.
module tb_div_unit_24bit;
  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clock = ~Clock;

  div_unit_24bit_if #(.WIDTH(24)) bus();
  div_unit_24bit #(.WIDTH(24)) dut (.Clock(Clock), .ResetN(ResetN), .bus(bus));

  typedef struct {
    logic [23:0] a, b, q, r;
    logic        z, dbz, ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [23:0] a, input logic [23:0] b);
    vec_t e;
    e.a = a; e.b = b; e.ovf = 1'b0;
    if (b == 24'h0) begin
      e.q = 24'hFFFFFF; e.r = a; e.dbz = 1'b1; e.z = 1'b0;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sb, sq, sr;
      sa = int'($signed(a)); sb = int'($signed(b));
      sq = sa / sb; sr = sa % sb;
      e.q = sq[23:0]; e.r = sr[23:0];
      e.ovf = (a == 24'h800000) && (b == 24'hFFFFFF);
`else
      e.q = a / b; e.r = a % b;
`endif
      e.dbz = 1'b0; e.z = (e.q == 24'h0);
    end
    return e;
  endfunction

  task automatic check_res(input string tag, input vec_t e);
    chk({tag, ".quotient"},  {8'h0, bus.Quotient},  {8'h0, e.q});
    chk({tag, ".remainder"}, {8'h0, bus.Remainder}, {8'h0, e.r});
    chk({tag, ".zero"},      {31'h0, bus.Zero},      {31'h0, e.z});
    chk({tag, ".divbyzero"}, {31'h0, bus.DivByZero}, {31'h0, e.dbz});
`ifdef DIV_SIGNED_EN
    chk({tag, ".overflow"},  {31'h0, bus.Overflow},  {31'h0, e.ovf});
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".busy"},      {31'h0, bus.Busy},      32'h0);
    chk({tag, ".done"},      {31'h0, bus.Done},      32'h0);
    chk({tag, ".quotient"},  {8'h0, bus.Quotient},   32'h0);
    chk({tag, ".remainder"}, {8'h0, bus.Remainder},  32'h0);
    chk({tag, ".zero"},      {31'h0, bus.Zero},      32'h1);
    chk({tag, ".divbyzero"}, {31'h0, bus.DivByZero}, 32'h0);
`ifdef DIV_SIGNED_EN
    chk({tag, ".overflow"},  {31'h0, bus.Overflow},  32'h0);
`endif
  endtask

  // Counts sampling points after the accept edge until Done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!bus.Done && n < 40);
  endtask

  task automatic issue(input vec_t e);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Dividend = e.a; bus.Divisor = e.b;
    sbq.push_back(e);
    @(posedge Clock);
    #1 bus.Start = 1'b0;
  endtask

  task automatic run_op(input string tag, input vec_t e);
    int   n;
    vec_t x;
    issue(e);
    wait_done(n);
    x = sbq.pop_front();
    chk({tag, ".latency"}, n, (x.b == 24'h0) ? 32'd1 : 32'd25);
    check_res(tag, x);
    @(negedge Clock);
    chk({tag, ".done_pulse"}, {31'h0, bus.Done}, 32'h0);
    chk({tag, ".hold_q"}, {8'h0, bus.Quotient}, {8'h0, x.q});
  endtask

  initial begin
    int   n, dones;
    vec_t e;
    bus.Start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;

    tbl.push_back('{24'd100,    24'd7,      24'd14,     24'd2,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'h0,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'd5,      24'd9,      24'd0,      24'd5,      1'b1, 1'b0, 1'b0});
    tbl.push_back('{24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{24'd50,     24'd5,      24'd10,     24'd0,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'd0,      24'd3,      24'd0,      24'd0,      1'b1, 1'b0, 1'b0});
`ifdef DIV_SIGNED_EN
    tbl.push_back('{24'hFFFFFF, 24'hFFFFFE, 24'd0,      24'hFFFFFF, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{24'h800000, 24'd3,      24'hD55556, 24'hFFFFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'hFFFF9C, 24'd7,      24'hFFFFF2, 24'hFFFFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'h800000, 24'hFFFFFF, 24'h800000, 24'h0,      1'b0, 1'b0, 1'b1});
    tbl.push_back('{24'd100,    24'hFFFFF9, 24'hFFFFF2, 24'd2,      1'b0, 1'b0, 1'b0});
`else
    tbl.push_back('{24'hFFFFFF, 24'hFFFFFE, 24'd1,      24'd1,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'h800000, 24'd3,      24'h2AAAAA, 24'd2,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'h800001, 24'h800000, 24'd1,      24'd1,      1'b0, 1'b0, 1'b0});
`endif

    repeat (3) @(negedge Clock);
    check_reset_vals("reset");
    ResetN = 1'b1;

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 12; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom);
      case (i % 3)
        0: b = 24'($urandom_range(1, 255));
        1: b = 24'($urandom);
        default: b = 24'($urandom_range(0, 4));
      endcase
      run_op($sformatf("rnd%0d", i), model(a, b));
    end

    // Start held high through RUN and FINISH with changing operands.
    @(negedge Clock);
    bus.Start = 1'b1; bus.Dividend = 24'd1000; bus.Divisor = 24'd10;
    @(posedge Clock);
    n = 0;
    do begin
      #1 bus.Dividend = 24'($urandom); bus.Divisor = 24'($urandom);
      @(negedge Clock);
      n++;
    end while (!bus.Done && n < 40);
    chk("hold_start.latency", n, 32'd25);
    check_res("hold_start", model(24'd1000, 24'd10));
    bus.Dividend = 24'd77; bus.Divisor = 24'd7;
    @(negedge Clock);
    chk("hold_start.busy_after_done", {31'h0, bus.Busy}, 32'h0);
    @(posedge Clock);
    #1 bus.Start = 1'b0;
    wait_done(n);
    chk("hold_start.second_latency", n, 32'd25);
    check_res("hold_start2", model(24'd77, 24'd7));

    // Reset in the middle of RUN.
    @(negedge Clock);
    bus.Start = 1'b1; bus.Dividend = 24'h001000; bus.Divisor = 24'd3;
    @(posedge Clock);
    #1 bus.Start = 1'b0;
    repeat (10) @(negedge Clock);
    chk("abort.busy_before", {31'h0, bus.Busy}, 32'h1);
    ResetN = 1'b0;
    #1 check_reset_vals("abort.in_reset");
    @(negedge Clock);
    check_reset_vals("abort.in_reset2");
    ResetN = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge Clock);
      if (bus.Done) dones++;
    end
    chk("abort.no_done", dones, 32'd0);
    run_op("after_abort", model(24'd50, 24'd5));

    chk("scoreboard.empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
